// File: rtl/decision_multi.sv
// decision_multi: tags ingress frames, gathers delayed per-channel verdicts
// and forwards or drops each egress frame by vote. Stats: DECISION_STATS_EN.
package decision_pkg;
  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  empty;
    logic        sop;
    logic        eop;
    logic        valid;
  } avln_st;
endpackage

module decision_multi
  import decision_pkg::*;
#(
  parameter int N_CH        = 4,
  parameter int DEPTH       = 16,
  parameter int FOUND_DELAY = 4,
  parameter int TIMEOUT     = 1024,
  localparam int TAG_W      = $clog2(DEPTH) + 1,
  localparam int CNT_W      = $clog2(N_CH + 1)
) (
  input  logic             sys_clk,
  input  logic             reset_n,
  input  avln_st           in,
  input  logic [N_CH-1:0]  start,
  input  logic [N_CH-1:0]  valid,
  input  logic [N_CH-1:0]  found,
  input  logic [1:0]       mode,
  input  logic [CNT_W-1:0] threshold,
  input  avln_st           fifo_out,
  output logic             fifo_rd,
  output avln_st           out,
  output logic             drop,
  output logic             overflow,
  output logic             proto_err,
  output logic [31:0]      n_pass,
  output logic [31:0]      n_drop,
  output logic [31:0]      n_tmo
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int TMR_W = $clog2(TIMEOUT + 1);
  localparam logic [TAG_W-1:0] DEPTH_T = TAG_W'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_STREAM} state_t;

  state_t           state;
  logic [TMR_W-1:0] timer;
  logic [TAG_W-1:0] wtag;
  logic [TAG_W-1:0] rtag;
  logic [TAG_W-1:0] inflight;
  logic [TAG_W-1:0] stag [N_CH];
  logic             pv   [N_CH][FOUND_DELAY];
  logic [TAG_W-1:0] pt   [N_CH][FOUND_DELAY];
  logic [N_CH-1:0]  tdone  [DEPTH];
  logic [N_CH-1:0]  tfound [DEPTH];
  logic [IDX_W-1:0] widx;
  logic [IDX_W-1:0] ridx;
  logic             isop;
  logic             ready;
  logic [CNT_W-1:0] cnt;
  logic             vote;
  logic             dec;
  logic             tmo_hit;
  logic             sop_pop;
  logic             bad_pop;
  logic             str_pop;
  logic             pop;
  logic             unused_in;
  logic [N_CH-1:0]  unused_msb;

  assign isop     = in.valid & in.sop;
  assign inflight = wtag - rtag;
  assign widx     = wtag[IDX_W-1:0];
  assign ridx     = rtag[IDX_W-1:0];
  assign ready    = &tdone[ridx];
  assign fifo_rd  = pop & reset_n;
  assign unused_in = ^{in.data, in.empty, in.eop};

  // Ingress tag allocation, per-channel start latch and verdict delay pipes.
  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      wtag     <= '0;
      overflow <= 1'b0;
      for (int c = 0; c < N_CH; c++) begin
        stag[c] <= '0;
        for (int s = 0; s < FOUND_DELAY; s++) begin
          pv[c][s] <= 1'b0;
          pt[c][s] <= '0;
        end
      end
    end else begin
      if (isop) begin
        wtag <= wtag + TAG_W'(1);
        if (inflight == DEPTH_T) overflow <= 1'b1;
      end
      for (int c = 0; c < N_CH; c++) begin
        if (start[c]) stag[c] <= wtag;
        pv[c][0] <= valid[c];
        pt[c][0] <= stag[c];
        for (int s = 1; s < FOUND_DELAY; s++) begin
          pv[c][s] <= pv[c][s-1];
          pt[c][s] <= pt[c][s-1];
        end
      end
    end
  end

  // Verdict table: an allocating clear beats a same-cycle verdict write.
  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int e = 0; e < DEPTH; e++) begin
        tdone[e]  <= '0;
        tfound[e] <= '0;
      end
    end else begin
      for (int e = 0; e < DEPTH; e++) begin
        for (int c = 0; c < N_CH; c++) begin
          if (isop && widx == IDX_W'(e)) begin
            tdone[e][c]  <= 1'b0;
            tfound[e][c] <= 1'b0;
          end else if (pv[c][FOUND_DELAY-1] &&
                       pt[c][FOUND_DELAY-1][IDX_W-1:0] == IDX_W'(e)) begin
            tdone[e][c]  <= 1'b1;
            tfound[e][c] <= found[c];
          end
        end
      end
    end
  end

  // Vote on the head entry and decide which head words to pop.
  always_comb begin
    cnt = '0;
    for (int c = 0; c < N_CH; c++) begin
      cnt = cnt + CNT_W'(tfound[ridx][c]);
      unused_msb[c] = pt[c][FOUND_DELAY-1][TAG_W-1];
    end
    vote = 1'b0;
    unique case (mode)
      2'd1:    vote = (cnt != '0);
      2'd2:    vote = (cnt >= threshold);
      2'd3:    vote = (cnt == CNT_W'(N_CH));
      default: vote = 1'b0;
    endcase
    tmo_hit = (state == S_WAIT) && !ready &&
              (timer == TMR_W'(TIMEOUT - 1));
    dec     = tmo_hit ? 1'b0 : vote;
    sop_pop = 1'b0;
    bad_pop = 1'b0;
    str_pop = 1'b0;
    unique case (state)
      S_IDLE: begin
        sop_pop = fifo_out.valid & fifo_out.sop & ready;
        bad_pop = fifo_out.valid & ~fifo_out.sop;
      end
      S_WAIT:   sop_pop = fifo_out.valid & (ready | tmo_hit);
      S_STREAM: str_pop = fifo_out.valid;
      default:  ;
    endcase
    pop = sop_pop | bad_pop | str_pop;
  end

  // Egress FSM with registered output word and frame drop flag.
  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      timer     <= '0;
      rtag      <= '0;
      drop      <= 1'b0;
      proto_err <= 1'b0;
      out       <= '0;
    end else begin
      out.valid <= 1'b0;
      if (pop) begin
        out.data  <= fifo_out.data;
        out.empty <= fifo_out.empty;
        out.sop   <= fifo_out.sop;
        out.eop   <= fifo_out.eop;
      end
      if (sop_pop) begin
        rtag      <= rtag + TAG_W'(1);
        drop      <= dec;
        out.valid <= ~dec;
        state     <= fifo_out.eop ? S_IDLE : S_STREAM;
      end else begin
        unique case (state)
          S_IDLE: begin
            if (bad_pop) begin
              proto_err <= 1'b1;
            end else if (fifo_out.valid && fifo_out.sop) begin
              state <= S_WAIT;
              timer <= '0;
            end
          end
          S_WAIT: timer <= timer + TMR_W'(1);
          S_STREAM: begin
            if (str_pop) begin
              out.valid <= ~drop;
              if (fifo_out.eop) state <= S_IDLE;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

`ifdef DECISION_STATS_EN
  // Frame statistics, wrapping at 2^32.
  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      n_pass <= '0;
      n_drop <= '0;
      n_tmo  <= '0;
    end else if (sop_pop) begin
      if (dec) n_drop <= n_drop + 32'd1;
      else     n_pass <= n_pass + 32'd1;
      if (tmo_hit) n_tmo <= n_tmo + 32'd1;
    end
  end
`else
  assign n_pass = '0;
  assign n_drop = '0;
  assign n_tmo  = '0;
`endif

endmodule

// File: tb/tb_decision_multi.sv
// tb_decision_multi: random and directed frames against a scoreboard
// model of the vote, verdict latency and timeout rules.
module tb_decision_multi;
  import decision_pkg::*;

  localparam int NC  = 4;
  localparam int DP  = 4;
  localparam int FD  = 4;
  localparam int TMO = 8;

  logic        sys_clk = 1'b0;
  logic        reset_n = 1'b0;
  avln_st      in_w;
  logic [3:0]  start, valid, found;
  logic [1:0]  mode;
  logic [2:0]  threshold;
  avln_st      head;
  logic        fifo_rd;
  avln_st      dout;
  logic        drop, overflow, proto_err;
  logic [31:0] n_pass, n_drop, n_tmo;

  int n_chk = 0;
  int n_fail = 0;
  int m_pass = 0;
  int m_drop = 0;
  int m_tmo = 0;
  bit rd_s;
  avln_st fq[$];
  avln_st eq[$];

  decision_multi #(
    .N_CH(NC), .DEPTH(DP), .FOUND_DELAY(FD), .TIMEOUT(TMO)
  ) dut (
    .sys_clk(sys_clk), .reset_n(reset_n), .in(in_w),
    .start(start), .valid(valid), .found(found),
    .mode(mode), .threshold(threshold), .fifo_out(head),
    .fifo_rd(fifo_rd), .out(dout), .drop(drop),
    .overflow(overflow), .proto_err(proto_err),
    .n_pass(n_pass), .n_drop(n_drop), .n_tmo(n_tmo)
  );

  always #5 sys_clk = ~sys_clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    avln_st e;
    @(negedge sys_clk);
    rd_s = fifo_rd;
    if (dout.valid) begin
      if (eq.size() == 0) chk("unexpected_out", 1, 0);
      else begin
        e = eq.pop_front();
        chk("out_data", dout.data, e.data);
        chk("out_sop", dout.sop, e.sop);
        chk("out_eop", dout.eop, e.eop);
        chk("out_empty", dout.empty, e.empty);
      end
    end
    @(posedge sys_clk);
    #1;
    if (rd_s && fq.size() > 0) void'(fq.pop_front());
    head = (fq.size() > 0) ? fq[0] : '0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    in_w = '0; start = '0; valid = '0; found = '0;
    fq.delete(); eq.delete(); head = '0;
    m_pass = 0; m_drop = 0; m_tmo = 0;
    repeat (2) @(posedge sys_clk);
    #1 reset_n = 1'b1;
    tick();
  endtask

  task automatic chk_stats(input string nm);
`ifdef DECISION_STATS_EN
    chk({nm, "_n_pass"}, n_pass, m_pass);
    chk({nm, "_n_drop"}, n_drop, m_drop);
    chk({nm, "_n_tmo"}, n_tmo, m_tmo);
`else
    chk({nm, "_n_pass"}, n_pass, 0);
    chk({nm, "_n_drop"}, n_drop, 0);
    chk({nm, "_n_tmo"}, n_tmo, 0);
`endif
  endtask

  task automatic run_frame(input logic [3:0] fpat, input logic [3:0] vmask,
                           input int len, input int fat,
                           input logic [1:0] md, input logic [2:0] th,
                           input string nm);
    avln_st frm[$];
    avln_st w;
    bit exp_drop;
    bit done;
    int cnt, pop_at, exp_lat;
    mode = md;
    threshold = th;
    cnt = $countones(fpat);
    if (vmask != 4'hF) exp_drop = 1'b0;
    else begin
      case (md)
        2'd0: exp_drop = 1'b0;
        2'd1: exp_drop = (cnt != 0);
        2'd2: exp_drop = (cnt >= int'(th));
        default: exp_drop = (cnt == NC);
      endcase
    end
    for (int i = 0; i < len; i++) begin
      w = '0;
      w.valid = 1'b1;
      w.sop = (i == 0);
      w.eop = (i == len - 1);
      w.data = $urandom;
      w.empty = 2'($urandom_range(0, 3));
      frm.push_back(w);
      if (!exp_drop) eq.push_back(w);
    end
    if (exp_drop) m_drop++;
    else m_pass++;
    if (vmask != 4'hF) m_tmo++;
    pop_at = -1;
    done = 1'b0;
    for (int k = 0; k < 60 && !done; k++) begin
      in_w = '0; start = '0; valid = '0;
      if (k == 0) begin
        in_w.valid = 1'b1; in_w.sop = 1'b1; start = 4'hF;
      end
      if (k == 1) valid = vmask;
      found = (k >= 1) ? fpat : 4'h0;
      if (k == fat) begin
        foreach (frm[i]) fq.push_back(frm[i]);
        head = fq[0];
      end
      tick();
      if (k >= fat && rd_s && pop_at < 0) pop_at = k;
      if (k >= fat && fq.size() == 0) done = 1'b1;
    end
    in_w = '0; start = '0; valid = '0;
    chk({nm, "_done"}, done, 1);
    if (vmask != 4'hF) exp_lat = TMO;
    else exp_lat = (fat >= FD + 2) ? 0 : FD + 2 - fat;
    chk({nm, "_lat"}, pop_at - fat, exp_lat);
    tick();
    found = '0;
    chk({nm, "_drop"}, drop, exp_drop);
    chk({nm, "_sb_left"}, eq.size(), 0);
  endtask

  initial begin
    avln_st w;
    int n;
    in_w = '0; start = '0; valid = '0; found = '0;
    mode = '0; threshold = '0; head = '0;
    #1;
    chk("rst_out", dout, 0);
    chk("rst_rd", fifo_rd, 0);
    do_reset();
    chk("rst_drop", drop, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_perr", proto_err, 0);
    chk_stats("rst");

    run_frame(4'b0000, 4'hF, 4, 6, 2'd1, 3'd0, "frameA");
    chk_stats("A");
    run_frame(4'b0100, 4'hF, 3, 6, 2'd1, 3'd0, "frameB");
    chk_stats("B");
    run_frame(4'b0011, 4'hF, 2, 7, 2'd2, 3'd2, "m2_0011");
    run_frame(4'b0001, 4'hF, 2, 7, 2'd2, 3'd2, "m2_0001");
    run_frame(4'b1110, 4'hF, 2, 7, 2'd3, 3'd0, "m3_1110");
    run_frame(4'b1111, 4'hF, 1, 7, 2'd3, 3'd0, "m3_1111");
    run_frame(4'b0000, 4'hF, 2, 7, 2'd2, 3'd0, "m2_thr0");
    run_frame(4'b0000, 4'b0111, 3, 3, 2'd1, 3'd0, "timeout");
    chk_stats("tmo");
    run_frame(4'b0000, 4'hF, 1, FD + 1, 2'd0, 3'd0, "same_cycle");
    run_frame(4'b0000, 4'hF, 2, FD + 2, 2'd0, 3'd0, "early");

    w = '0; w.valid = 1'b1; w.eop = 1'b1; w.data = $urandom;
    fq.push_back(w);
    head = fq[0];
    chk("perr_before", proto_err, 0);
    tick();
    chk("perr_pop", rd_s, 1);
    tick();
    chk("perr_outv", dout.valid, 0);
    chk("perr_sticky", proto_err, 1);

    for (int r = 0; r < 25; r++) begin
      run_frame(4'($urandom_range(0, 15)),
                ($urandom_range(0, 5) == 0) ? 4'b1011 : 4'hF,
                $urandom_range(1, 4), $urandom_range(1, 9),
                2'($urandom_range(0, 3)), 3'($urandom_range(0, 5)),
                "rand");
    end
    chk_stats("rand");

    mode = 2'd0;
    in_w.valid = 1'b1; in_w.sop = 1'b1; start = 4'hF;
    tick();
    in_w = '0; start = '0; valid = 4'hF;
    tick();
    valid = '0;
    for (int i = 0; i < 6; i++) begin
      w = '0; w.valid = 1'b1; w.sop = (i == 0); w.eop = (i == 5);
      w.data = $urandom;
      fq.push_back(w);
      eq.push_back(w);
    end
    repeat (4) tick();
    head = fq[0];
    n = 0;
    while (fq.size() > 3 && n < 30) begin
      tick();
      n++;
    end
    chk("mid_stream", fq.size(), 3);
    chk("pre_rst_outv", dout.valid, 1);
    reset_n = 1'b0;
    #1;
    chk("rst_async_outv", dout.valid, 0);
    chk("rst_async_rd", fifo_rd, 0);
    chk("rst_async_drop", drop, 0);
    do_reset();
    chk_stats("post_rst");
    run_frame(4'b0010, 4'hF, 3, 6, 2'd1, 3'd0, "post_rst");
    chk_stats("post_rst_fr");

    do_reset();
    for (int i = 0; i < 5; i++) begin
      in_w = '0; in_w.valid = 1'b1; in_w.sop = 1'b1;
      tick();
      in_w = '0;
      if (i == 3) chk("ovf_at4", overflow, 0);
    end
    chk("ovf_at5", overflow, 1);
    repeat (3) tick();
    chk("ovf_sticky", overflow, 1);
    do_reset();
    chk("ovf_cleared", overflow, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
